// File: rtl/wave_pwm_dac.sv
// wave_pwm_dac: converts the signed DDS sample into a 1-bit DAC stream,
// either frame-based PWM or first-order sigma-delta. One sample is latched
// per 2^WIDTH-enabled-cycle frame.
// Ports:
//   clock_in         system clock, rising edge
//   reset_in         synchronous active-high reset
//   enable_in        advance enable; low freezes state and forces outputs low
//   mode_in          0 = PWM, 1 = sigma-delta; taken at the load edge only
//   sample_in        signed two's-complement sample
//   pwm_out          registered 1-bit stream
//   frame_strobe_out registered 1-cycle pulse after each load edge
//   sample_held_out  sample latched at the last load edge
module wave_pwm_dac #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             clock_in,
  input  logic             reset_in,
  input  logic             enable_in,
  input  logic             mode_in,
  input  logic [WIDTH-1:0] sample_in,
  output logic             pwm_out,
  output logic             frame_strobe_out,
  output logic [WIDTH-1:0] sample_held_out
);

  localparam int unsigned SUM_W = WIDTH + 1;
  localparam logic [WIDTH-1:0] DUTY_RST = WIDTH'(2 ** (WIDTH - 1));

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             mode_q, mode_d;
  logic             pwm_q, pwm_d;
  logic             strobe_q, strobe_d;
  logic [WIDTH-1:0] held_q, held_d;

  logic             load;
  logic [WIDTH-1:0] code;
  logic [WIDTH-1:0] duty_eff;
  logic             mode_eff;
  logic [WIDTH-1:0] acc_base;
  logic [SUM_W-1:0] sum;

  // Datapath and next-state
  always_comb begin
    // Offset binary: flipping the sign bit maps -2^(W-1)..2^(W-1)-1 onto 0..2^W-1
    code     = {~sample_in[WIDTH-1], sample_in[WIDTH-2:0]};
    load     = enable_in && (cnt_q == '0);
    duty_eff = load ? code : duty_q;
    mode_eff = load ? mode_in : mode_q;
    // Entering a new mode starts the accumulator from zero
    acc_base = (load && (mode_in != mode_q)) ? '0 : acc_q;
    sum      = SUM_W'(acc_base) + SUM_W'(duty_eff);

    cnt_d    = cnt_q;
    duty_d   = duty_q;
    acc_d    = acc_q;
    mode_d   = mode_q;
    held_d   = held_q;
    pwm_d    = 1'b0;
    strobe_d = 1'b0;

    if (enable_in) begin
      cnt_d = cnt_q + WIDTH'(1);
      if (load) begin
        duty_d   = code;
        held_d   = sample_in;
        mode_d   = mode_in;
        strobe_d = 1'b1;
      end
      if (!mode_eff) begin
        pwm_d = (cnt_q < duty_eff);
      end else begin
        acc_d = sum[WIDTH-1:0];
        pwm_d = sum[WIDTH];
      end
    end
  end

  // State registers
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      cnt_q    <= '0;
      duty_q   <= DUTY_RST;
      acc_q    <= '0;
      mode_q   <= 1'b0;
      pwm_q    <= 1'b0;
      strobe_q <= 1'b0;
      held_q   <= '0;
    end else begin
      cnt_q    <= cnt_d;
      duty_q   <= duty_d;
      acc_q    <= acc_d;
      mode_q   <= mode_d;
      pwm_q    <= pwm_d;
      strobe_q <= strobe_d;
      held_q   <= held_d;
    end
  end

  assign pwm_out          = pwm_q;
  assign frame_strobe_out = strobe_q;
  assign sample_held_out  = held_q;

endmodule

// File: tb/tb_wave_pwm_dac.sv
// Directed self-checking bench for wave_pwm_dac (WIDTH = 6, 64-cycle frames).
module tb_wave_pwm_dac;

  localparam int unsigned WIDTH = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             mode;
  logic [WIDTH-1:0] sample;
  logic             pwm;
  logic             strobe;
  logic [WIDTH-1:0] held;

  int tests = 0;
  int fails = 0;

  wave_pwm_dac #(.WIDTH(WIDTH)) dut (
    .clock_in        (clk),
    .reset_in        (rst),
    .enable_in       (en),
    .mode_in         (mode),
    .sample_in       (sample),
    .pwm_out         (pwm),
    .frame_strobe_out(strobe),
    .sample_held_out (held)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance n cycles, recording pwm bits and strobe positions
  task automatic run_cycles(input int n, output logic [63:0] bits,
                            output int nstrobe, output int strobe_idx);
    bits = '0;
    nstrobe = 0;
    strobe_idx = -1;
    for (int i = 0; i < n; i++) begin
      step();
      bits[i] = pwm;
      if (strobe) begin
        nstrobe++;
        if (strobe_idx < 0) strobe_idx = i;
      end
    end
  endtask

  function automatic logic [63:0] pwm_exp(input int d);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) r[i] = (i < d);
    return r;
  endfunction

  task automatic sd_exp(input int d, input int acc_in, output logic [63:0] bits,
                        output int acc_out);
    int a;
    int s;
    a = acc_in;
    bits = '0;
    for (int i = 0; i < 64; i++) begin
      s = a + d;
      bits[i] = (s >= 64);
      a = s % 64;
    end
    acc_out = a;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; mode = 1'b0; sample = 6'd5;
    step(); step();
    tests++; if (pwm !== 1'b0) begin fails++; $display("FAIL reset_pwm: got %b expected 0", pwm); end
    tests++; if (strobe !== 1'b0) begin fails++; $display("FAIL reset_strobe: got %b expected 0", strobe); end
    tests++; if (held !== 6'd0) begin fails++; $display("FAIL reset_held: got %h expected 00", held); end
    rst = 1'b0; en = 1'b0;
    step();
    tests++; if (strobe !== 1'b0 || pwm !== 1'b0) begin fails++; $display("FAIL idle_outputs: got strobe %b pwm %b expected 0 0", strobe, pwm); end
  endtask

  task automatic test_pwm_mid();
    logic [63:0] bits;
    int ns, si;
    en = 1'b1; sample = 6'd0; mode = 1'b0;
    for (int f = 0; f < 2; f++) begin
      run_cycles(64, bits, ns, si);
      tests++; if (bits !== pwm_exp(32)) begin fails++; $display("FAIL mid_bits f%0d: got %h expected %h", f, bits, pwm_exp(32)); end
      tests++; if (ns !== 1 || si !== 0) begin fails++; $display("FAIL mid_strobe f%0d: got count %0d idx %0d expected 1 0", f, ns, si); end
      tests++; if (held !== 6'd0) begin fails++; $display("FAIL mid_held f%0d: got %h expected 00", f, held); end
    end
  endtask

  task automatic test_pwm_boundaries();
    logic [5:0] samples [3];
    int duties [3];
    logic [63:0] bits;
    int ns, si;
    samples[0] = 6'h20; duties[0] = 0;
    samples[1] = 6'h1F; duties[1] = 63;
    samples[2] = 6'h10; duties[2] = 48;
    for (int k = 0; k < 3; k++) begin
      sample = samples[k];
      run_cycles(64, bits, ns, si);
      tests++; if (bits !== pwm_exp(duties[k])) begin fails++; $display("FAIL bound_bits d%0d: got %h expected %h", duties[k], bits, pwm_exp(duties[k])); end
      tests++; if ($countones(bits) != duties[k]) begin fails++; $display("FAIL bound_ones d%0d: got %0d expected %0d", duties[k], $countones(bits), duties[k]); end
      tests++; if (held !== samples[k]) begin fails++; $display("FAIL bound_held: got %h expected %h", held, samples[k]); end
    end
  endtask

  task automatic test_sample_change();
    logic [63:0] ba, bb, all;
    int ns, si;
    sample = 6'd10;
    run_cycles(20, ba, ns, si);
    tests++; if (held !== 6'd10) begin fails++; $display("FAIL chg_held_a: got %h expected 0a", held); end
    sample = 6'h36;
    run_cycles(44, bb, ns, si);
    tests++; if (held !== 6'd10) begin fails++; $display("FAIL chg_held_b: got %h expected 0a", held); end
    tests++; if (ns !== 0) begin fails++; $display("FAIL chg_strobe: got %0d expected 0", ns); end
    all = ba | (bb << 20);
    tests++; if (all !== pwm_exp(42)) begin fails++; $display("FAIL chg_frame1: got %h expected %h", all, pwm_exp(42)); end
    run_cycles(64, all, ns, si);
    tests++; if (all !== pwm_exp(22)) begin fails++; $display("FAIL chg_frame2: got %h expected %h", all, pwm_exp(22)); end
    tests++; if (held !== 6'h36) begin fails++; $display("FAIL chg_held_c: got %h expected 36", held); end
  endtask

  task automatic test_sigma_delta();
    logic [63:0] bits, ba, bb, ex;
    int ns, si, acc_m, acc_n;
    mode = 1'b1; sample = 6'd0;
    run_cycles(64, bits, ns, si);
    tests++; if (bits !== 64'hAAAA_AAAA_AAAA_AAAA) begin fails++; $display("FAIL sd_zero: got %h expected aaaaaaaaaaaaaaaa", bits); end
    acc_m = 0;
    sample = 6'h10;
    sd_exp(48, acc_m, ex, acc_n); acc_m = acc_n;
    run_cycles(64, bits, ns, si);
    tests++; if (bits !== ex) begin fails++; $display("FAIL sd_48_bits: got %h expected %h", bits, ex); end
    tests++; if ($countones(bits) != 48) begin fails++; $display("FAIL sd_48_ones: got %0d expected 48", $countones(bits)); end
    // mode_in dropped mid-frame: frame stays sigma-delta
    sd_exp(48, acc_m, ex, acc_n); acc_m = acc_n;
    run_cycles(20, ba, ns, si);
    mode = 1'b0;
    run_cycles(44, bb, ns, si);
    tests++; if ((ba | (bb << 20)) !== ex) begin fails++; $display("FAIL sd_toggle_hold: got %h expected %h", ba | (bb << 20), ex); end
    run_cycles(20, ba, ns, si);
    mode = 1'b1;
    run_cycles(44, bb, ns, si);
    tests++; if ((ba | (bb << 20)) !== pwm_exp(48)) begin fails++; $display("FAIL sd_to_pwm: got %h expected %h", ba | (bb << 20), pwm_exp(48)); end
    sd_exp(48, 0, ex, acc_n);
    run_cycles(64, bits, ns, si);
    tests++; if (bits !== ex) begin fails++; $display("FAIL pwm_to_sd: got %h expected %h", bits, ex); end
  endtask

  task automatic test_enable_gap();
    logic [63:0] ba, bb;
    int ns, si;
    logic [5:0] held_before;
    mode = 1'b0; sample = 6'd0;
    run_cycles(30, ba, ns, si);
    held_before = held;
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      tests++; if (pwm !== 1'b0 || strobe !== 1'b0) begin fails++; $display("FAIL gap_out c%0d: got pwm %b strobe %b expected 0 0", i, pwm, strobe); end
    end
    tests++; if (held !== held_before) begin fails++; $display("FAIL gap_held: got %h expected %h", held, held_before); end
    en = 1'b1;
    run_cycles(34, bb, ns, si);
    tests++; if (bb !== 64'h3) begin fails++; $display("FAIL gap_tail: got %h expected 3", bb); end
    tests++; if (ns !== 0) begin fails++; $display("FAIL gap_early_strobe: got %0d expected 0", ns); end
    tests++; if ((ba | (bb << 30)) !== pwm_exp(32)) begin fails++; $display("FAIL gap_frame: got %h expected %h", ba | (bb << 30), pwm_exp(32)); end
    step();
    tests++; if (strobe !== 1'b1) begin fails++; $display("FAIL gap_strobe: got %b expected 1", strobe); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] ba, bb;
    int ns, si;
    run_cycles(63, ba, ns, si);
    sample = 6'h14;
    run_cycles(40, ba, ns, si);
    tests++; if (held !== 6'h14 || pwm !== 1'b1) begin fails++; $display("FAIL pre_reset: got held %h pwm %b expected 14 1", held, pwm); end
    rst = 1'b1;
    step();
    tests++; if (pwm !== 1'b0 || strobe !== 1'b0 || held !== 6'd0) begin fails++; $display("FAIL mid_reset: got pwm %b strobe %b held %h expected 0 0 00", pwm, strobe, held); end
    rst = 1'b0; sample = 6'd5;
    run_cycles(1, ba, ns, si);
    tests++; if (ns !== 1 || held !== 6'd5 || pwm !== 1'b1) begin fails++; $display("FAIL post_reset_load: got strobe %0d held %h pwm %b expected 1 05 1", ns, held, pwm); end
    run_cycles(63, bb, ns, si);
    tests++; if ((ba | (bb << 1)) !== pwm_exp(37)) begin fails++; $display("FAIL post_reset_frame: got %h expected %h", ba | (bb << 1), pwm_exp(37)); end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0; sample = '0;
    test_reset();
    test_pwm_mid();
    test_pwm_boundaries();
    test_sample_change();
    test_sigma_delta();
    test_enable_gap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wave_pwm_dac.md
# wave_pwm_dac

Output stage placed directly downstream of the DDS amplitude multiplier. It consumes the signed 6-bit scaled waveform sample and converts it to a single-bit stream that drives an output pin through an external RC filter. Two conversion modes are supported: frame-based PWM, and first-order sigma-delta. A new sample is latched once per 2^WIDTH-cycle frame, so each frame carries exactly one sample.

## Interface

Parameters
- WIDTH, 6, sample width in bits; frame length is 2^WIDTH enabled cycles

Ports
- clock_in  input  1  system clock; all logic on its rising edge
- reset_in  input  1  synchronous, active-high reset
- enable_in  input  1  advance enable; low freezes all state
- mode_in  input  1  0 = PWM, 1 = sigma-delta; sampled only at a load edge
- sample_in  input  WIDTH  signed two's-complement sample from the DDS amplitude stage
- pwm_out  output  1  registered 1-bit DAC stream
- frame_strobe_out  output  1  registered 1-cycle pulse following each load edge
- sample_held_out  output  WIDTH  signed sample latched at the last load edge

## Operation

- Offset conversion: code = sample_in with its MSB inverted (unsigned, 0..2^WIDTH-1).
  - For WIDTH=6: -32 maps to 0, 0 maps to 32, +31 maps to 63.
- Frame counter cnt (WIDTH bits):
  - Increments on every edge where enable_in=1.
  - Wraps from 2^WIDTH-1 to 0.
- Load edge: an edge with enable_in=1 and cnt==0. On a load edge:
  - duty_reg <= code.
  - sample_held_out <= sample_in.
  - mode_reg <= mode_in.
  - frame_strobe_out <= 1.
  - On every other edge, frame_strobe_out <= 0.
- duty_eff = code on a load edge, duty_reg otherwise.
  - sample_in is ignored between load edges.
  - A mode_in change mid-frame takes effect at the next load edge.
- PWM mode (mode_reg==0 after the load, i.e. the mode being loaded on a load edge):
  - pwm_out <= (cnt < duty_eff).
  - Duty 0 gives pwm_out never high. Duty 2^WIDTH-1 gives pwm_out high for 63 of 64 cycles.
- Sigma-delta mode, with accumulator acc of WIDTH bits:
  - {carry, acc} <= acc + duty_eff (WIDTH+1-bit sum).
  - pwm_out <= carry.
  - If the load edge changes mode_reg, the sum uses acc=0.
  - With acc=0 at frame start and constant duty d, the frame has exactly d ones and acc returns to 0.
- acc is held, not updated, while in PWM mode.
- enable_in=0:
  - cnt, acc, duty_reg, mode_reg and sample_held_out hold.
  - pwm_out <= 0 and frame_strobe_out <= 0.
  - Resuming continues the frame from the held cnt.
- Arithmetic: all comparisons are unsigned on WIDTH bits. The accumulator add is WIDTH+1 bits with the carry as the output bit. There is no saturation; the full code range is legal.

## Timing

- Reset values (reset_in high on an edge, which overrides enable_in):
  - cnt=0, duty_reg=2^(WIDTH-1), acc=0, mode_reg=0.
  - pwm_out=0, frame_strobe_out=0, sample_held_out=0.
- First enabled edge after reset release is a load edge.
- Latency:
  - frame_strobe_out and sample_held_out update 1 cycle after the load edge.
  - pwm_out reflects the new duty in the same registered cycle (bit for cnt=0 appears right after the load edge).
- PWM frame: pwm_out is high for the first duty_eff enabled cycles after the load edge, then low until the next load edge.
- Frame period is 2^WIDTH enabled cycles. Disabled cycles stretch the frame without altering its content.
- Reset mid-frame:
  - Everything returns to reset values on that edge.
  - The next enabled edge after release loads a fresh sample.
- Simultaneous reset_in and enable_in: reset wins.

## Test plan

- Reset, then enable with sample_in=0, mode 0 -> frame_strobe_out pulses every 64 cycles; pwm_out has 32 highs then 32 lows per frame; sample_held_out=0.
- Mode 0 boundaries: sample_in=-32 -> pwm_out never high; sample_in=+31 -> 63 highs and 1 low per frame; sample_in=+16 -> 48 highs per frame.
- Change sample_in mid-frame (10 to -10 at cnt=20) -> current frame keeps duty 42; next frame duty 22; sample_held_out changes only after the load edge.
- Mode 1, sample_in=0 from frame start -> pwm_out = 0,1,0,1,…; sample_in=+16 -> exactly 48 ones per 64-cycle frame; mode_in toggled mid-frame -> switch occurs only at the next load edge, with acc cleared.
- enable_in low for 5 cycles at cnt=30 -> pwm_out=0 and state frozen during the gap; after resume the frame completes with the correct remaining high count, and the next strobe is delayed by exactly 5 cycles.
- reset_in asserted at cnt=40 with enable_in=1 -> next cycle all outputs are 0 and cnt=0; the first enabled edge after release loads the sample and strobes.
